// File: rtl/ddr_cmd_pkg.sv
// rtl/ddr_cmd_pkg.sv - command codes, bank count, FSM states and bank index helper
package ddr_cmd_pkg;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_REF = 4'd1;
    localparam logic [3:0] CMD_ACT = 4'd2;
    localparam logic [3:0] CMD_RD  = 4'd3;
    localparam logic [3:0] CMD_WR  = 4'd4;
    localparam logic [3:0] CMD_PRE = 4'd5;

    localparam int NUM_BANKS = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PRE_I,
        ST_PRE_C,
        ST_ACT_I,
        ST_ACT_C,
        ST_RW_I,
        ST_RW_C,
        ST_RSCAN,
        ST_RPRE_I,
        ST_RPRE_C,
        ST_REF_I,
        ST_REF_C
    } issuer_state_t;

    // Flat bank index: bg*4 + bank.
    function automatic logic [3:0] bank_idx(input logic [1:0] bg, input logic [1:0] bank);
        return {bg, bank};
    endfunction

endpackage

// File: rtl/ddr_open_row_table.sv
// rtl/ddr_open_row_table.sv - per-bank open-row table with combinational lookup
module ddr_open_row_table
    import ddr_cmd_pkg::*;
#(
    parameter int ROW_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [3:0]       i_idx,
    input  logic [ROW_W-1:0] i_row,
    input  logic             i_set,
    input  logic             i_clr,
    output logic             o_open,
    output logic             o_hit
);

    logic [NUM_BANKS-1:0] r_valid;
    logic [ROW_W-1:0]     r_row [NUM_BANKS];

    // Valid bits: cleared together on reset, set on ACT accept, cleared on PRE accept.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= '0;
        end else if (i_set) begin
            r_valid[i_idx] <= 1'b1;
        end else if (i_clr) begin
            r_valid[i_idx] <= 1'b0;
        end
    end

    // Row storage needs no reset: it is only meaningful while its valid bit is set.
    always_ff @(posedge i_clk) begin
        if (i_set) begin
            r_row[i_idx] <= i_row;
        end
    end

    assign o_open = r_valid[i_idx];
    assign o_hit  = r_valid[i_idx] && (r_row[i_idx] == i_row);

endmodule

// File: rtl/ddr_cmd_issuer.sv
// rtl/ddr_cmd_issuer.sv - PRE/ACT/RD/WR/REF issuer with retry and refresh; optional DDR_ISSUER_STATS_EN counters
module ddr_cmd_issuer
    import ddr_cmd_pkg::*;
#(
    parameter int ROW_W = 16,
    parameter int TREFI = 7800
`ifdef DDR_ISSUER_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [1:0]       req_bg,
    input  logic [1:0]       req_bank,
    input  logic [ROW_W-1:0] req_row,
    output logic             req_ready,
    output logic [3:0]       tc_cmd,
    output logic [1:0]       tc_bg,
    output logic [1:0]       tc_bank,
    input  logic             tc_ready,
    output logic             ref_busy
`ifdef DDR_ISSUER_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_retry_cnt,
    output logic [CNT_W-1:0] stat_cmd_cnt
`endif
);

    localparam int REF_W = (TREFI > 2) ? $clog2(TREFI) : 1;
    localparam logic [REF_W-1:0] REF_RELOAD = REF_W'(TREFI - 1);

    issuer_state_t    r_state;
    logic [3:0]       r_tc_cmd;
    logic [1:0]       r_tc_bg;
    logic [1:0]       r_tc_bank;
    logic             r_req_ready;
    logic             r_ref_busy;
    logic [3:0]       r_scan_idx;
    logic [REF_W-1:0] r_ref_cnt;
    logic             r_ref_pending;

    logic       w_in_ref;
    logic [3:0] w_req_idx;
    logic [3:0] w_tbl_idx;
    logic [3:0] w_rw_cmd;
    logic       w_set;
    logic       w_clr;
    logic       w_open;
    logic       w_hit;

    assign w_in_ref  = r_state inside {ST_RSCAN, ST_RPRE_I, ST_RPRE_C, ST_REF_I, ST_REF_C};
    assign w_req_idx = bank_idx(req_bg, req_bank);
    assign w_tbl_idx = w_in_ref ? r_scan_idx : w_req_idx;
    assign w_rw_cmd  = req_we ? CMD_WR : CMD_RD;
    assign w_set     = (r_state == ST_ACT_C) && tc_ready;
    assign w_clr     = ((r_state == ST_PRE_C) || (r_state == ST_RPRE_C)) && tc_ready;

    ddr_open_row_table #(
        .ROW_W (ROW_W)
    ) u_row_table (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_idx   (w_tbl_idx),
        .i_row   (req_row),
        .i_set   (w_set),
        .i_clr   (w_clr),
        .o_open  (w_open),
        .o_hit   (w_hit)
    );

    // Refresh interval timer; an expiry while a refresh is still owed is simply dropped.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_ref_cnt     <= REF_RELOAD;
            r_ref_pending <= 1'b0;
        end else begin
            if (r_ref_cnt == '0) begin
                r_ref_cnt <= REF_RELOAD;
            end else begin
                r_ref_cnt <= r_ref_cnt - REF_W'(1);
            end
            if (r_state == ST_REF_C) begin
                r_ref_pending <= 1'b0;
            end else if (r_ref_cnt == '0) begin
                r_ref_pending <= 1'b1;
            end
        end
    end

    // Issue/check FSM: each command is shown for one cycle, then a NOP cycle samples the verdict.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state     <= ST_IDLE;
            r_tc_cmd    <= CMD_NOP;
            r_tc_bg     <= 2'd0;
            r_tc_bank   <= 2'd0;
            r_req_ready <= 1'b0;
            r_ref_busy  <= 1'b0;
            r_scan_idx  <= 4'd0;
        end else begin
            r_tc_cmd    <= CMD_NOP;
            r_req_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_ref_pending) begin
                        r_state    <= ST_RSCAN;
                        r_scan_idx <= 4'd0;
                        r_ref_busy <= 1'b1;
                    end else if (req_valid && !r_req_ready) begin
                        // The cycle req_ready is high the requester still holds the old request.
                        r_tc_bg   <= req_bg;
                        r_tc_bank <= req_bank;
                        if (w_hit) begin
                            r_state  <= ST_RW_I;
                            r_tc_cmd <= w_rw_cmd;
                        end else if (w_open) begin
                            r_state  <= ST_PRE_I;
                            r_tc_cmd <= CMD_PRE;
                        end else begin
                            r_state  <= ST_ACT_I;
                            r_tc_cmd <= CMD_ACT;
                        end
                    end
                end
                ST_PRE_I: r_state <= ST_PRE_C;
                ST_PRE_C: begin
                    r_state  <= tc_ready ? ST_ACT_I : ST_PRE_I;
                    r_tc_cmd <= tc_ready ? CMD_ACT : CMD_PRE;
                end
                ST_ACT_I: r_state <= ST_ACT_C;
                ST_ACT_C: begin
                    r_state  <= tc_ready ? ST_RW_I : ST_ACT_I;
                    r_tc_cmd <= tc_ready ? w_rw_cmd : CMD_ACT;
                end
                ST_RW_I: r_state <= ST_RW_C;
                ST_RW_C: begin
                    if (tc_ready) begin
                        r_state     <= ST_IDLE;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_state  <= ST_RW_I;
                        r_tc_cmd <= w_rw_cmd;
                    end
                end
                ST_RSCAN: begin
                    if (w_open) begin
                        r_state   <= ST_RPRE_I;
                        r_tc_cmd  <= CMD_PRE;
                        r_tc_bg   <= r_scan_idx[3:2];
                        r_tc_bank <= r_scan_idx[1:0];
                    end else if (r_scan_idx == 4'd15) begin
                        r_state   <= ST_REF_I;
                        r_tc_cmd  <= CMD_REF;
                        r_tc_bg   <= 2'd0;
                        r_tc_bank <= 2'd0;
                    end else begin
                        r_scan_idx <= r_scan_idx + 4'd1;
                    end
                end
                ST_RPRE_I: r_state <= ST_RPRE_C;
                ST_RPRE_C: begin
                    if (!tc_ready) begin
                        r_state  <= ST_RPRE_I;
                        r_tc_cmd <= CMD_PRE;
                    end else if (r_scan_idx == 4'd15) begin
                        r_state   <= ST_REF_I;
                        r_tc_cmd  <= CMD_REF;
                        r_tc_bg   <= 2'd0;
                        r_tc_bank <= 2'd0;
                    end else begin
                        r_state    <= ST_RSCAN;
                        r_scan_idx <= r_scan_idx + 4'd1;
                    end
                end
                ST_REF_I: r_state <= ST_REF_C;
                ST_REF_C: begin
                    // REF carries no verdict: the sequence ends here regardless of tc_ready.
                    r_state    <= ST_IDLE;
                    r_ref_busy <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tc_cmd    = r_tc_cmd;
    assign tc_bg     = r_tc_bg;
    assign tc_bank   = r_tc_bank;
    assign req_ready = r_req_ready;
    assign ref_busy  = r_ref_busy;

`ifdef DDR_ISSUER_STATS_EN
    logic [CNT_W-1:0] r_retry_cnt;
    logic [CNT_W-1:0] r_cmd_cnt;
    logic             w_check;

    assign w_check = r_state inside {ST_PRE_C, ST_ACT_C, ST_RW_C, ST_RPRE_C};

    // Saturating counters of refused verdicts and of completed commands (REF counted once).
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_retry_cnt <= '0;
            r_cmd_cnt   <= '0;
        end else begin
            if (w_check && !tc_ready && (r_retry_cnt != '1)) begin
                r_retry_cnt <= r_retry_cnt + CNT_W'(1);
            end
            if (((w_check && tc_ready) || (r_state == ST_REF_C)) && (r_cmd_cnt != '1)) begin
                r_cmd_cnt <= r_cmd_cnt + CNT_W'(1);
            end
        end
    end

    assign stat_retry_cnt = r_retry_cnt;
    assign stat_cmd_cnt   = r_cmd_cnt;
`endif

endmodule

// File: tb/tb_ddr_cmd_issuer.sv
// tb/tb_ddr_cmd_issuer.sv - self-checking bench with transaction-level command model
module tb_ddr_cmd_issuer;
    import ddr_cmd_pkg::*;

    localparam int ROW_W = 16;
    localparam int TREFI = 64;

    logic             sys_clk   = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_we    = 1'b0;
    logic [1:0]       req_bg    = 2'd0;
    logic [1:0]       req_bank  = 2'd0;
    logic [ROW_W-1:0] req_row   = '0;
    logic             req_ready;
    logic [3:0]       tc_cmd;
    logic [1:0]       tc_bg;
    logic [1:0]       tc_bank;
    logic             tc_ready  = 1'b0;
    logic             ref_busy;
`ifdef DDR_ISSUER_STATS_EN
    logic [15:0]      stat_retry_cnt;
    logic [15:0]      stat_cmd_cnt;
`endif

    always #5 sys_clk = ~sys_clk;

    ddr_cmd_issuer #(
        .ROW_W (ROW_W),
        .TREFI (TREFI)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .req_valid      (req_valid),
        .req_we         (req_we),
        .req_bg         (req_bg),
        .req_bank       (req_bank),
        .req_row        (req_row),
        .req_ready      (req_ready),
        .tc_cmd         (tc_cmd),
        .tc_bg          (tc_bg),
        .tc_bank        (tc_bank),
        .tc_ready       (tc_ready),
        .ref_busy       (ref_busy)
`ifdef DDR_ISSUER_STATS_EN
        ,
        .stat_retry_cnt (stat_retry_cnt),
        .stat_cmd_cnt   (stat_cmd_cnt)
`endif
    );

    typedef struct {
        logic [3:0] cmd;
        logic [1:0] bg;
        logic [1:0] bank;
        int         nref;
        bit         rf;
    } exp_t;

    exp_t             exp_q[$];
    bit               m_valid[16];
    logic [ROW_W-1:0] m_row[16];
    int               n_cmp = 0;
    int               n_bad = 0;

    bit   in_check     = 1'b0;
    bit   acc          = 1'b0;
    bit   popq         = 1'b0;
    bit   ready_due    = 1'b0;
    bit   busy_low_due = 1'b0;
    exp_t cur;
    int   rpre_seen    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic void push_cmd(input logic [3:0] c, input int idx, input int nref, input bit rf);
        exp_t e;
        e.cmd  = c;
        e.bg   = 2'(idx / 4);
        e.bank = 2'(idx % 4);
        e.nref = nref;
        e.rf   = rf;
        exp_q.push_back(e);
    endfunction

    // Expected commands for one request, from the row-buffer rules.
    function automatic void model_req(input bit we, input int idx, input logic [ROW_W-1:0] row,
                                      input int nr_pre, input int nr_act, input int nr_rw);
        if (!(m_valid[idx] && m_row[idx] == row)) begin
            if (m_valid[idx]) push_cmd(CMD_PRE, idx, nr_pre, 1'b0);
            push_cmd(CMD_ACT, idx, nr_act, 1'b0);
            m_valid[idx] = 1'b1;
            m_row[idx]   = row;
        end
        push_cmd(we ? CMD_WR : CMD_RD, idx, nr_rw, 1'b0);
    endfunction

    // Expected refresh: precharge every open bank in ascending order, then REF.
    function automatic void model_refresh(input int nr_pre);
        for (int i = 0; i < 16; i++) begin
            if (m_valid[i]) push_cmd(CMD_PRE, i, nr_pre, 1'b1);
            m_valid[i] = 1'b0;
        end
        push_cmd(CMD_REF, 0, 0, 1'b1);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        exp_q.delete();
    endfunction

    // Timing-controller responder and per-cycle comparison against the expected stream.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            in_check     = 1'b0;
            ready_due    = 1'b0;
            busy_low_due = 1'b0;
            tc_ready     = 1'b0;
        end else begin
            check("req_ready", req_ready, ready_due);
            ready_due = 1'b0;
            if (busy_low_due) begin
                check("ref_busy_drop", ref_busy, 0);
                busy_low_due = 1'b0;
            end
            if (in_check) begin
                check("check_nop", tc_cmd, CMD_NOP);
                in_check = 1'b0;
                if (cur.cmd == CMD_REF) begin
                    tc_ready = 1'b0;
                    check("ref_busy_refc", ref_busy, 1);
                    busy_low_due = 1'b1;
                end else begin
                    tc_ready = acc;
                    if (acc && (cur.cmd == CMD_RD || cur.cmd == CMD_WR)) ready_due = 1'b1;
                end
                if (acc && popq && exp_q.size() != 0) void'(exp_q.pop_front());
            end else if (tc_cmd != CMD_NOP) begin
                in_check = 1'b1;
                tc_ready = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_cmd", tc_cmd, CMD_NOP);
                    cur.cmd = tc_cmd;
                    acc     = 1'b1;
                    popq    = 1'b0;
                end else begin
                    cur = exp_q[0];
                    check("cmd", tc_cmd, cur.cmd);
                    check("bg", tc_bg, cur.bg);
                    check("bank", tc_bank, cur.bank);
                    check("ref_busy_issue", ref_busy, cur.rf);
                    if (cur.rf && cur.cmd == CMD_PRE) rpre_seen++;
                    popq = 1'b1;
                    if (cur.nref > 0) begin
                        acc = 1'b0;
                        exp_q[0] = '{cmd: cur.cmd, bg: cur.bg, bank: cur.bank, nref: cur.nref - 1, rf: cur.rf};
                    end else begin
                        acc = 1'b1;
                    end
                end
            end else begin
                tc_ready = 1'b0;
            end
        end
    end

    task automatic drive_req(input bit we, input int bg, input int bank, input int row);
        bit got = 1'b0;
        req_we    = we;
        req_bg    = 2'(bg);
        req_bank  = 2'(bank);
        req_row   = ROW_W'(row);
        req_valid = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge sys_clk);
            #1;
            if (req_ready) got = 1'b1;
        end
        req_valid = 1'b0;
        check("req_done", got, 1);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || in_check) && n < budget) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        req_valid = 1'b0;
        model_reset();
        @(posedge sys_clk);
        #1;
        check("rst_tc_cmd", tc_cmd, CMD_NOP);
        check("rst_tc_bg", tc_bg, 0);
        check("rst_tc_bank", tc_bank, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_ref_busy", ref_busy, 0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // 1: closed bank 6, read row 5, RD refused 17 times
        model_req(1'b0, 6, 5, 0, 0, 17);
        check("t1_len", exp_q.size(), 2);
        check("t1_first", exp_q[0].cmd, CMD_ACT);
        drive_req(1'b0, 1, 2, 5);
        wait_drain(20);
`ifdef DDR_ISSUER_STATS_EN
        check("t1_retry_cnt", stat_retry_cnt, 17);
        check("t1_cmd_cnt", stat_cmd_cnt, 2);
`endif

        // 2: row hit, single RD
        model_req(1'b0, 6, 5, 0, 0, 0);
        check("t2_len", exp_q.size(), 1);
        check("t2_cmd", exp_q[0].cmd, CMD_RD);
        drive_req(1'b0, 1, 2, 5);
        wait_drain(20);

        // 3: row miss write row 9 -> PRE, ACT, WR; a following read of row 9 hits
        model_req(1'b1, 6, 9, 0, 0, 0);
        check("t3_len", exp_q.size(), 3);
        check("t3_seq0", exp_q[0].cmd, CMD_PRE);
        check("t3_seq2", exp_q[2].cmd, CMD_WR);
        drive_req(1'b1, 1, 2, 9);
        model_req(1'b0, 6, 9, 0, 0, 0);
        drive_req(1'b0, 1, 2, 9);
        model_refresh(0);
        wait_drain(120);

        // 4: banks 0 and 7 open, refresh precharges exactly those then REF
        do_reset();
        model_req(1'b0, 0, 1, 0, 0, 0);
        model_req(1'b1, 7, 2, 0, 0, 0);
        model_refresh(0);
        check("t4_len", exp_q.size(), 7);
        check("t4_rpre1_bank", exp_q[5].bank, 3);
        drive_req(1'b0, 0, 0, 1);
        drive_req(1'b1, 1, 3, 2);
        wait_drain(150);
        check("t4_busy_idle", ref_busy, 0);
        model_req(1'b0, 0, 1, 0, 0, 0);
        check("t4_reopen", exp_q[0].cmd, CMD_ACT);
        drive_req(1'b0, 0, 0, 1);
        wait_drain(20);

        // 5: refresh expires while ACT is being retried; RD completes first
        do_reset();
        model_req(1'b0, 9, 3, 0, 6, 0);
        model_refresh(1000);
        repeat (56) @(posedge sys_clk);
        #1;
        rpre_seen = 0;
        drive_req(1'b0, 2, 1, 3);

        // 6: reset in the middle of the refresh precharge retry
        for (int i = 0; i < 100 && rpre_seen < 2; i++) begin
            @(posedge sys_clk);
            #1;
        end
        check("t6_rpre_retried", rpre_seen >= 2, 1);
        check("t6_busy_before", ref_busy, 1);
        do_reset();
        model_req(1'b0, 9, 3, 0, 0, 0);
        check("t6_first", exp_q[0].cmd, CMD_ACT);
        drive_req(1'b0, 2, 1, 3);
        wait_drain(20);

        repeat (4) @(posedge sys_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
